// File: rtl/mux7_scan_ctrl.sv
// mux7_scan_ctrl: steps the mux7to1 select through enabled channels and assembles the sampled 7-bit word
module mux7_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] ch_mask,
  input  logic       z_in,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [6:0] data_out
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [6:0] mask;
  logic [3:0] cnt;
  logic [6:0] above;
  function automatic logic [2:0] lowest(input logic [6:0] m);
    lowest = 3'd0;
    for (int i = 6; i >= 0; i--) if (m[i]) lowest = 3'(i);
  endfunction
  // enabled channels strictly above the current one; the shifted-out top bit keeps sel from reaching 7
  assign above = mask & (7'h7E << sel);
  assign busy = state == WAIT;
  assign done = state == DONE;
  // scan sequencer: hold each channel SETTLE cycles, sample on the last one, then advance or finish
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 3'd0;
      mask     <= 7'd0;
      cnt      <= 4'd0;
      data_out <= 7'd0;
    end else if (state == IDLE) begin
      if (start) begin
        data_out <= 7'd0;
        if (|ch_mask) begin
          mask  <= ch_mask;
          sel   <= lowest(ch_mask);
          cnt   <= 4'(SETTLE - 1);
          state <= WAIT;
        end else begin
          state <= DONE;
        end
      end
    end else if (state == WAIT) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        data_out[sel] <= z_in;
        if (|above) begin
          sel <= lowest(above);
          cnt <= 4'(SETTLE - 1);
        end else begin
          state <= DONE;
        end
      end
    end else begin
      sel   <= 3'd0;
      state <= IDLE;
    end
  end
endmodule
